// File: rtl/axis_pkt_stats.sv
// rtl/axis_pkt_stats.sv - per-packet beat count and data sum, emitted as a 2-beat summary stream
module axis_pkt_stats #(
    parameter int DATA_WIDTH    = 32,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [PKT_CNT_WIDTH-1:0] pkt_done_cnt
);

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        SEND_CNT = 2'd1,
        SEND_SUM = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [DATA_WIDTH-2:0] beat_cnt;
    logic [DATA_WIDTH-1:0] sum;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] sum_hold;

    logic                  in_hs;
    logic [DATA_WIDTH-2:0] cnt_inc;
    logic [DATA_WIDTH-1:0] sum_add;
    logic                  carry;

    // s_axis_tready is a register that is only high in ACCUM, so it doubles as the accept qualifier
    assign in_hs   = s_axis_tvalid & s_axis_tready;
    assign cnt_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
    assign {carry, sum_add} = {1'b0, sum} + {1'b0, s_axis_tdata};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: leave ACCUM on the last input beat, step through the two summary beats on downstream ready
    always_comb begin
        next_state = state;
        case (state)
            ACCUM:    if (in_hs && s_axis_tlast) next_state = SEND_CNT;
            SEND_CNT: if (m_axis_tready)         next_state = SEND_SUM;
            SEND_SUM: if (m_axis_tready)         next_state = ACCUM;
            default:                             next_state = ACCUM;
        endcase
    end

    // Accumulators, registered summary outputs, registered input ready and completed-packet counter
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt      <= '0;
            sum           <= '0;
            ovf           <= 1'b0;
            sum_hold      <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            pkt_done_cnt  <= '0;
        end else begin
            // registered from next_state so m_axis_tready never reaches s_axis_tready combinationally
            s_axis_tready <= (next_state == ACCUM);
            case (state)
                ACCUM: begin
                    if (in_hs) begin
                        if (s_axis_tlast) begin
                            m_axis_tdata  <= {ovf | carry, cnt_inc};
                            sum_hold      <= sum_add;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b0;
                            beat_cnt      <= '0;
                            sum           <= '0;
                            ovf           <= 1'b0;
                        end else begin
                            beat_cnt <= cnt_inc;
                            sum      <= sum_add;
                            ovf      <= ovf | carry;
                        end
                    end
                end
                SEND_CNT: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= sum_hold;
                        m_axis_tlast <= 1'b1;
                    end
                end
                SEND_SUM: begin
                    if (m_axis_tready) begin
                        m_axis_tdata  <= '0;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        pkt_done_cnt  <= pkt_done_cnt + 1'b1;
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_stats.sv
// tb/tb_axis_pkt_stats.sv - scoreboard bench for axis_pkt_stats
module tb_axis_pkt_stats;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] pkt_done_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] sb_q[$];
    int          exp_pkts;
    int          out_beats = 0;
    bit          rand_rdy = 1'b0;
    logic        fixed_rdy = 1'b1;

    logic [30:0] m_cnt;
    logic [31:0] m_sum;
    logic        m_ovf;

    logic        stall = 1'b0;
    logic [32:0] prev_out;

    axis_pkt_stats #(.DATA_WIDTH(32), .PKT_CNT_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_done_cnt  (pkt_done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // downstream ready: fixed level or random, updated just after each rising edge
    always @(posedge clk) begin
        #2;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end

    // output monitor: scoreboard compare on handshakes, stability while stalled
    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 64'(m_axis_tvalid), 64'(1));
                check("hold_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_out));
                check("hold_in_rdy_low", 64'(s_axis_tready), 64'(0));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_beats++;
                if (sb_q.size() == 0) check("sb_extra_beat", 64'(1), 64'(0));
                else check("sb_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(sb_q.pop_front()));
            end
            stall    = m_axis_tvalid && !m_axis_tready;
            prev_out = {m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic model_clear();
        m_cnt = '0;
        m_sum = '0;
        m_ovf = 1'b0;
    endtask

    // called just after a rising edge; returns just after the accepting edge
    task automatic send_beat(input logic [31:0] d, input logic l);
        logic        hs;
        int          n;
        logic [32:0] t;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 500) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check("in_accept_timeout", 64'(0), 64'(1));
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        t = {1'b0, m_sum} + {1'b0, d};
        m_ovf = m_ovf | t[32];
        m_sum = t[31:0];
        if (m_cnt != '1) m_cnt = m_cnt + 31'd1;
        if (l) begin
            sb_q.push_back({1'b0, m_ovf, m_cnt});
            sb_q.push_back({1'b1, m_sum});
            exp_pkts++;
            model_clear();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) check("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_pkts = 0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lowc;
        int b0;
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_pkts      = 0;
        model_clear();

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy", 64'(s_axis_tready), 64'(0));
        check("rst_out_valid", 64'(m_axis_tvalid), 64'(0));
        check("rst_out_last", 64'(m_axis_tlast), 64'(0));
        check("rst_out_data", 64'(m_axis_tdata), 64'(0));
        check("rst_pkt_cnt", 64'(pkt_done_cnt), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rdy_reset_cycle", 64'(s_axis_tready), 64'(0));
        @(posedge clk);
        #1;
        check("rdy_after_reset", 64'(s_axis_tready), 64'(1));

        // 21-beat ramp, summary beat 0 valid right after the tlast handshake
        for (int i = 0; i <= 20; i++) send_beat(32'(i), i == 20);
        check("lat_b0_valid", 64'(m_axis_tvalid), 64'(1));
        check("lat_b0_data", 64'(m_axis_tdata), 64'(32'h0000_0015));
        check("lat_b0_last", 64'(m_axis_tlast), 64'(0));
        drain();
        check("pkt_cnt_ramp", 64'(pkt_done_cnt), 64'(1));

        // single-beat packet, input ready low for exactly two cycles
        send_beat(32'hDEAD_BEEF, 1'b1);
        lowc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s_axis_tready) break;
            lowc++;
        end
        @(posedge clk);
        #1;
        check("single_rdy_low_cycles", 64'(lowc), 64'(2));
        drain();
        check("pkt_cnt_single", 64'(pkt_done_cnt), 64'(2));

        // sum carry sets ovf, next packet starts clean
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'h0000_0002, 1'b1);
        send_beat(32'h0000_0005, 1'b1);
        drain();
        check("pkt_cnt_ovf", 64'(pkt_done_cnt), 64'(4));

        // backpressure on both summary beats, next input beat held valid throughout
        fixed_rdy = 1'b0;
        @(posedge clk);
        #1;
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b1);
        b0 = out_beats;
        s_axis_tdata  = 32'd9;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        sb_q.push_back({1'b0, 32'h0000_0001});
        sb_q.push_back({1'b1, 32'h0000_0009});
        exp_pkts++;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        fixed_rdy = 1'b1;
        @(posedge clk);
        #1;
        fixed_rdy = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        fixed_rdy = 1'b1;
        @(negedge clk);
        check("bp_rdy_in_send_sum", 64'(s_axis_tready), 64'(0));
        @(posedge clk);
        #1;
        check("bp_out_beats", 64'(out_beats - b0), 64'(2));
        @(negedge clk);
        check("bp_rdy_returns", 64'(s_axis_tready), 64'(1));
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("bp_held_beat_taken", 64'(m_axis_tvalid), 64'(1));
        drain();
        check("pkt_cnt_bp", 64'(pkt_done_cnt), 64'(6));

        // reset mid-packet discards the partial packet
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b0);
        pulse_reset();
        send_beat(32'd7, 1'b0);
        send_beat(32'd8, 1'b1);
        drain();
        check("pkt_cnt_after_reset", 64'(pkt_done_cnt), 64'(1));

        // 300 back-to-back 4-beat packets with random downstream ready
        pulse_reset();
        rand_rdy = 1'b1;
        for (int p = 0; p < 300; p++) begin
            for (int b = 0; b < 4; b++) send_beat($urandom, b == 3);
        end
        drain();
        rand_rdy = 1'b0;
        check("pkt_cnt_300", 64'(pkt_done_cnt), 64'(300));
        check("sb_empty_end", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
